// File: rtl/mux_pkg.sv
// Shared definitions for the registered one-hot mux: the state encoding of the
// output skid stage, default sizes and a one-hot test used by the optional
// select checker (MUX_ONEHOT_REG_SELCHK_EN).
package mux_pkg;

    localparam int W_DEF = 8;
    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // True when exactly one bit of v is set; callers zero-extend sel to 16 bits.
    function automatic logic is_onehot(input logic [15:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 16; i++) cnt += {31'd0, v[i]};
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/mux_onehot_sel.sv
// Combinational AND-OR selector: each output bit is the OR over all channels of
// (select bit AND channel bit). A zero select gives zero; multi-hot ORs channels.
module mux_onehot_sel #(
    parameter int W = 8,
    parameter int N = 8
) (
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   sel,
    output logic [W-1:0]   out_data
);

    // Accumulate every gated channel into the output word.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N; k++) begin
            out_data = out_data | (in_data[k*W +: W] & {W{sel[k]}});
        end
    end

endmodule

// File: rtl/mux_onehot_reg.sv
// Registered one-hot mux with a 2-entry skid output stage (main + skid).
// in_ready is a flop, so out_ready never reaches it combinationally; the skid
// entry absorbs the beat accepted in the cycle the downstream stalls.
// Define MUX_ONEHOT_REG_SELCHK_EN to build the one-hot checker driving sel_err;
// such flagged beats carry all-zero data. Without it sel_err is constant 0.
module mux_onehot_reg
    import mux_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0] sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sel_err
);

    logic [W-1:0] sel_data;
    logic [W-1:0] beat_data;
    logic         accept;
    logic         drain;

    state_e       state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         vld_q, vld_d;
    logic         rdy_q, rdy_d;

    mux_onehot_sel #(.W(W), .N(N)) u_sel (
        .in_data  (in_data),
        .sel      (sel),
        .out_data (sel_data)
    );

`ifdef MUX_ONEHOT_REG_SELCHK_EN
    logic beat_err;
    logic main_err_q, main_err_d;
    logic skid_err_q, skid_err_d;

    // Flag any select that is not exactly one-hot and squash its data.
    always_comb begin
        beat_err  = !is_onehot(16'(sel));
        beat_data = beat_err ? '0 : sel_data;
    end
`else
    assign beat_data = sel_data;
`endif

    assign accept = in_valid && rdy_q;
    assign drain  = vld_q && out_ready;

    // Next-state of the skid stage: load, spill to skid, refill from skid.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
`ifdef MUX_ONEHOT_REG_SELCHK_EN
        main_err_d = main_err_q;
        skid_err_d = skid_err_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = beat_data;
`ifdef MUX_ONEHOT_REG_SELCHK_EN
                    main_err_d = beat_err;
`endif
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    skid_d  = beat_data;
`ifdef MUX_ONEHOT_REG_SELCHK_EN
                    skid_err_d = beat_err;
`endif
                    state_d = ST_FULL;
                end else if (accept) begin
                    main_d  = beat_data;
`ifdef MUX_ONEHOT_REG_SELCHK_EN
                    main_err_d = beat_err;
`endif
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    main_d  = skid_q;
`ifdef MUX_ONEHOT_REG_SELCHK_EN
                    main_err_d = skid_err_q;
`endif
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        vld_d = (state_d != ST_EMPTY);
        rdy_d = (state_d != ST_FULL);
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
`ifdef MUX_ONEHOT_REG_SELCHK_EN
            main_err_q <= 1'b0;
            skid_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
`ifdef MUX_ONEHOT_REG_SELCHK_EN
            main_err_q <= main_err_d;
            skid_err_q <= skid_err_d;
`endif
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_data  = main_q;
`ifdef MUX_ONEHOT_REG_SELCHK_EN
    assign sel_err   = main_err_q;
`else
    assign sel_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_onehot_reg.sv
// Directed bench for mux_onehot_reg: reset, latency, skid fill/drain order,
// streaming, select-error behaviour and a reset taken while FULL, plus a
// scoreboard sweep over two extra parameter points (W=16,N=2 and W=1,N=16).
module tb_mux_onehot_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [7:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;

    logic         sw_rst_n;
    logic [255:0] sw_data;
    logic [15:0]  sw_sel;
    logic         sw_in_valid;
    logic         sw_out_ready;
    logic         a_in_ready, a_out_valid, a_sel_err;
    logic [15:0]  a_out_data;
    logic         b_in_ready, b_out_valid, b_sel_err;
    logic [0:0]   b_out_data;

    int checks = 0;
    int errors = 0;

`ifdef MUX_ONEHOT_REG_SELCHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    mux_onehot_reg #(.W(8), .N(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
    );

    mux_onehot_reg #(.W(16), .N(2)) dut_a (
        .clk(clk), .rst_n(sw_rst_n), .in_data(sw_data[31:0]), .sel(sw_sel[1:0]),
        .in_valid(sw_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(sw_out_ready), .sel_err(a_sel_err)
    );

    mux_onehot_reg #(.W(1), .N(16)) dut_b (
        .clk(clk), .rst_n(sw_rst_n), .in_data(sw_data[15:0]), .sel(sw_sel),
        .in_valid(sw_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(sw_out_ready), .sel_err(b_sel_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = '0; in_data = '0;
        tick(); tick();
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        if (sel_err !== 1'b0)   begin errors++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %b want 0", out_valid); end
    endtask

    task automatic test_latency();
        in_data = '0; in_data[2*8 +: 8] = 8'hA5; sel = 8'h04;
        out_ready = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", out_valid); end
        if (out_data !== 8'hA5) begin errors++; $display("FAIL latency_data got %h want a5", out_data); end
        if (sel_err !== 1'b0)   begin errors++; $display("FAIL latency_sel_err got %b want 0", sel_err); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_drain got %b want 0", out_valid); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0; sel = 8'h01; in_data = '0;
        in_data[7:0] = 8'h11; in_valid = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_one got %b want 1", in_ready); end
        in_data[7:0] = 8'h22;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_full got %b want 0", in_ready); end
        in_data[7:0] = 8'h33;
        tick();
        checks += 3;
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL skid_hold_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL skid_hold_valid got %b want 1", out_valid); end
        if (out_data !== 8'h11) begin errors++; $display("FAIL skid_hold_data got %h want 11", out_data); end
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_data !== 8'h22) begin errors++; $display("FAIL skid_second got %h want 22", out_data); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL skid_ready_back got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (out_data !== 8'h33) begin errors++; $display("FAIL skid_third got %h want 33", out_data); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL skid_third_valid got %b want 1", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        out_ready = 1'b1; sel = 8'h08; in_data = '0; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp = 8'(i * 7 + 1);
            in_data[3*8 +: 8] = exp;
            tick();
            checks += 3;
            if (out_data !== exp)   begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, out_data, exp); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
            if (in_ready !== 1'b1)  begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", out_valid); end
    endtask

    task automatic test_sel_err();
        in_data = '0; in_data[1*8 +: 8] = 8'h0F; in_data[2*8 +: 8] = 8'hF0;
        out_ready = 1'b1; in_valid = 1'b1;
        sel = 8'h06;
        tick();
        checks += 2;
        if (out_data !== (CHK ? 8'h00 : 8'hFF)) begin errors++; $display("FAIL multihot_data got %h want %h", out_data, CHK ? 8'h00 : 8'hFF); end
        if (sel_err !== CHK) begin errors++; $display("FAIL multihot_err got %b want %b", sel_err, CHK); end
        sel = 8'h00;
        tick();
        checks += 2;
        if (out_data !== 8'h00) begin errors++; $display("FAIL zerosel_data got %h want 00", out_data); end
        if (sel_err !== CHK)    begin errors++; $display("FAIL zerosel_err got %b want %b", sel_err, CHK); end
        sel = 8'h04;
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (out_data !== 8'hF0) begin errors++; $display("FAIL onehot_data got %h want f0", out_data); end
        if (sel_err !== 1'b0)   begin errors++; $display("FAIL onehot_err got %b want 0", sel_err); end
        tick();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0; sel = 8'h01; in_data = '0; in_valid = 1'b1;
        in_data[7:0] = 8'hA1; tick();
        in_data[7:0] = 8'hB2; tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rstfull_full got %b want 0", in_ready); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstfull_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_stale[%0d] got %b want 0", i, out_valid); end
        end
    endtask

    // Random one-hot traffic with random backpressure against a FIFO model.
    task automatic test_sweep(input int w, input int n, input bit which);
        logic [15:0] q[$];
        logic [15:0] exp, got;
        logic        rdy, vld, err;
        int          k;
        sw_rst_n = 1'b0; sw_in_valid = 1'b0; sw_out_ready = 1'b0; sw_sel = '0; sw_data = '0;
        tick();
        sw_rst_n = 1'b1;
        for (int c = 0; c < 340; c++) begin
            if (c < 300) begin
                for (int i = 0; i < 8; i++) sw_data[i*32 +: 32] = $urandom;
                k = $urandom_range(n - 1, 0);
                sw_sel = 16'(1) << k;
                sw_in_valid = ($urandom_range(3, 0) != 0);
                sw_out_ready = $urandom_range(1, 0) != 0;
            end else begin
                sw_in_valid = 1'b0;
                sw_out_ready = 1'b1;
            end
            #1;
            rdy = which ? b_in_ready : a_in_ready;
            vld = which ? b_out_valid : a_out_valid;
            err = which ? b_sel_err : a_sel_err;
            got = which ? {15'd0, b_out_data} : a_out_data;
            if (vld) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL sweep_w%0d_n%0d_extra got %h want none", w, n, got);
                end else if (got !== q[0] || err !== 1'b0) begin
                    errors++; $display("FAIL sweep_w%0d_n%0d_data got %h/%b want %h/0", w, n, got, err, q[0]);
                end
                if (sw_out_ready && q.size() != 0) void'(q.pop_front());
            end
            if (sw_in_valid && rdy) begin
                exp = '0;
                for (int j = 0; j < w; j++) exp[j] = sw_data[k*w + j];
                q.push_back(exp);
            end
            tick();
        end
        checks += 2;
        if (q.size() != 0) begin errors++; $display("FAIL sweep_w%0d_n%0d_loss got %0d left want 0", w, n, q.size()); end
        vld = which ? b_out_valid : a_out_valid;
        if (vld !== 1'b0) begin errors++; $display("FAIL sweep_w%0d_n%0d_idle got %b want 0", w, n, vld); end
    endtask

    initial begin
        sw_rst_n = 1'b0; sw_in_valid = 1'b0; sw_out_ready = 1'b0; sw_sel = '0; sw_data = '0;
        test_reset();
        test_latency();
        test_skid();
        test_back_to_back();
        test_sel_err();
        test_reset_full();
        test_sweep(16, 2, 1'b0);
        test_sweep(1, 16, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
